// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg
// Shared definitions for the register-file write-port arbiter:
//   - widths of register addresses and data
//   - write-source encoding reported on rf_w_src
//   - starvation FSM state encoding
//   - addr_onehot(): one-hot decode of a register address
package wb_port_arbiter_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NUM_REGS = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    localparam logic WB_SRC_PIPE = 1'b0;
    localparam logic WB_SRC_LU   = 1'b1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_STEAL = 2'd2;

    function automatic logic [NUM_REGS-1:0] addr_onehot(input reg_addr_t a);
        return {{(NUM_REGS-1){1'b0}}, 1'b1} << a;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if
// Bundles the pipeline write-back request, the long-latency result
// handshake and the register-file write port with its side-band outputs.
//   pipe_w_ena/addr/data     : pipeline write-back request
//   lu_valid/lu_ready/addr/data : long-latency result handshake
//   rf_w_ena/addr/data/src   : registered register-file write
//   pipe_stall_req           : request for one write-back bubble
//   pend_vec                 : registers targeted by live queued results
// master = the side driving requests (pipeline/long-latency unit/bench),
// slave  = the arbiter.
interface wb_port_arbiter_if;
    import wb_port_arbiter_pkg::*;

    logic                pipe_w_ena;
    reg_addr_t           pipe_w_addr;
    reg_data_t           pipe_w_data;
    logic                lu_valid;
    logic                lu_ready;
    reg_addr_t           lu_addr;
    reg_data_t           lu_data;
    logic                rf_w_ena;
    reg_addr_t           rf_w_addr;
    reg_data_t           rf_w_data;
    logic                rf_w_src;
    logic                pipe_stall_req;
    logic [NUM_REGS-1:0] pend_vec;

    modport master (
        output pipe_w_ena, pipe_w_addr, pipe_w_data,
        output lu_valid, lu_addr, lu_data,
        input  lu_ready,
        input  rf_w_ena, rf_w_addr, rf_w_data, rf_w_src,
        input  pipe_stall_req, pend_vec
    );

    modport slave (
        input  pipe_w_ena, pipe_w_addr, pipe_w_data,
        input  lu_valid, lu_addr, lu_data,
        output lu_ready,
        output rf_w_ena, rf_w_addr, rf_w_data, rf_w_src,
        output pipe_stall_req, pend_vec
    );

endinterface

// File: rtl/wb_port_arbiter_lu.sv
// wb_lu_fifo
// Queue of long-latency results waiting for a free write slot.
//   clk, resetn          : clock, synchronous active-low reset
//   push/push_addr/data  : enqueue one result at the tail
//   pop                  : remove the head entry
//   kill_ena/kill_addr   : pipeline write this cycle; live entries with the
//                          same destination become dead
//   ready                : count < DEPTH (from registered count only)
//   head_valid/live/addr/data : head entry view
//   pend_vec             : registered OR of one-hot(addr) over live entries
module wb_lu_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                push,
    input  reg_addr_t           push_addr,
    input  reg_data_t           push_data,
    input  logic                pop,
    input  logic                kill_ena,
    input  reg_addr_t           kill_addr,
    output logic                ready,
    output logic                head_valid,
    output logic                head_live,
    output reg_addr_t           head_addr,
    output reg_data_t           head_data,
    output logic [NUM_REGS-1:0] pend_vec
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    reg_addr_t           addr_q [DEPTH];
    reg_data_t           data_q [DEPTH];
    reg_addr_t           addr_n [DEPTH];
    logic [DEPTH-1:0]    live_q, live_n;
    logic [PW-1:0]       rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]       count_q, count_n;
    logic [NUM_REGS-1:0] pend_q, pend_n;

    assign ready      = (count_q < CW'(DEPTH));
    assign head_valid = (count_q != '0);
    assign head_live  = live_q[rd_ptr_q];
    assign head_addr  = addr_q[rd_ptr_q];
    assign head_data  = data_q[rd_ptr_q];
    assign pend_vec   = pend_q;

    // Next-state live bits: the pipeline write kills older matching entries,
    // a popped slot is cleared, and a same-cycle push is born dead when the
    // pipeline write targets the same register (the pipeline op is younger).
    // pend_vec is then rebuilt from the post-update view.
    always_comb begin
        live_n  = live_q;
        pend_n  = '0;
        count_n = count_q + CW'(push) - CW'(pop);
        for (int i = 0; i < DEPTH; i++) begin
            addr_n[i] = addr_q[i];
            if (kill_ena && live_q[i] && (addr_q[i] == kill_addr)) begin
                live_n[i] = 1'b0;
            end
        end
        if (pop) begin
            live_n[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            addr_n[wr_ptr_q] = push_addr;
            live_n[wr_ptr_q] = !(kill_ena && (kill_addr == push_addr));
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (live_n[i]) begin
                pend_n = pend_n | addr_onehot(addr_n[i]);
            end
        end
    end

    // Control state: pointers wrap naturally at power-of-two DEPTH.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            live_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            pend_q   <= '0;
        end else begin
            live_q  <= live_n;
            count_q <= count_n;
            pend_q  <= pend_n;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
        end
    end

    // Entry payload needs no reset; validity is tracked by count/live.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= push_addr;
            data_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the register-file write port between pipeline write-back and the
// long-latency unit. Pipeline writes win; queued results drain into idle
// slots; a starvation FSM asks for a bubble when the queue head is blocked
// for STARVE_LIMIT consecutive cycles.
//   clk    : clock
//   resetn : synchronous active-low reset
//   bus    : wb_port_arbiter_if slave modport (all request/write signals)
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               resetn,
    wb_port_arbiter_if.slave  bus
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic       fifo_ready, head_valid, head_live, push, pop, blocked;
    reg_addr_t  head_addr;
    reg_data_t  head_data;
    logic       rf_w_ena_q, rf_w_src_q, stall_q;
    reg_addr_t  rf_w_addr_q;
    reg_data_t  rf_w_data_q;
    logic [1:0] state_q, state_n;
    logic [3:0] cnt_q, cnt_n;

    // Results for $0 complete the handshake but are never queued.
    assign push    = bus.lu_valid && fifo_ready && (bus.lu_addr != '0);
    assign pop     = !bus.pipe_w_ena && head_valid;
    assign blocked = bus.pipe_w_ena && head_valid;

    wb_lu_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (push),
        .push_addr  (bus.lu_addr),
        .push_data  (bus.lu_data),
        .pop        (pop),
        .kill_ena   (bus.pipe_w_ena),
        .kill_addr  (bus.pipe_w_addr),
        .ready      (fifo_ready),
        .head_valid (head_valid),
        .head_live  (head_live),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .pend_vec   (bus.pend_vec)
    );

    assign bus.lu_ready       = fifo_ready;
    assign bus.rf_w_ena       = rf_w_ena_q;
    assign bus.rf_w_addr      = rf_w_addr_q;
    assign bus.rf_w_data      = rf_w_data_q;
    assign bus.rf_w_src       = rf_w_src_q;
    assign bus.pipe_stall_req = stall_q;

    // Write slot selection. A dead head is still popped but produces no
    // write, and address/data hold their previous values when idle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rf_w_ena_q  <= 1'b0;
            rf_w_addr_q <= '0;
            rf_w_data_q <= '0;
            rf_w_src_q  <= WB_SRC_PIPE;
        end else if (bus.pipe_w_ena) begin
            rf_w_ena_q  <= 1'b1;
            rf_w_addr_q <= bus.pipe_w_addr;
            rf_w_data_q <= bus.pipe_w_data;
            rf_w_src_q  <= WB_SRC_PIPE;
        end else if (head_valid && head_live) begin
            rf_w_ena_q  <= 1'b1;
            rf_w_addr_q <= head_addr;
            rf_w_data_q <= head_data;
            rf_w_src_q  <= WB_SRC_LU;
        end else begin
            rf_w_ena_q  <= 1'b0;
        end
    end

    // Starvation FSM: the first blocked cycle counts as 1, so the bubble
    // request appears after STARVE_LIMIT blocked cycles. Any pop or an
    // empty queue returns to IDLE.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_n = '0;
                if (blocked) begin
                    cnt_n   = 4'd1;
                    state_n = (4'd1 >= LIMIT) ? ST_STEAL : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!head_valid || pop) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else if (blocked) begin
                    cnt_n = cnt_q + 4'd1;
                    if (cnt_n >= LIMIT) begin
                        state_n = ST_STEAL;
                    end
                end
            end
            ST_STEAL: begin
                if (!head_valid || pop) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // State register; the bubble request is registered off the next state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            stall_q <= (state_n == ST_STEAL);
        end
    end

endmodule
